gated_shift_pipe: RTL and testbench

Parametrised, enable-gated delay line: the next generation of the team's 8-bit enabled capture register, generalised to WIDTH bits and DEPTH stages.
- Adds per-stage valid tracking, a synchronous flush, an occupancy count and a programmable reset value.
- Sits between a producer and a consumer that share one clock.
- Balances datapath latency against a parallel path, with `en` acting as a global stall.

---
 rtl/gated_shift_pipe_pkg.sv | 13 +
 rtl/gated_stage.sv | 36 +++
 rtl/gated_shift_pipe.sv | 57 +++++
 tb/tb_gated_shift_pipe.sv | 104 ++++++++++
 4 files changed

// File: rtl/gated_shift_pipe_pkg.sv
// gated_shift_pipe_pkg: shared sizing and counting helpers for the gated delay line
package gated_shift_pipe_pkg;
  localparam int MAX_DEPTH = 256;
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int popcount(input logic [MAX_DEPTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_DEPTH; i++) n += int'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/gated_stage.sv
// gated_stage: one enable-gated data register with its valid bit
module gated_stage
  import gated_shift_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             flush,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v_out,
  output logic [WIDTH-1:0] d_out
);
  logic [WIDTH-1:0] d_q, d_d;
  logic             v_q, v_d;
  // flush beats enable; otherwise capture on enable or hold
  always_comb begin
    d_d = flush ? RESET_VAL : en ? d_in : d_q;
    v_d = flush ? 1'b0 : en ? v_in : v_q;
  end
  // stage state, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q <= RESET_VAL;
      v_q <= 1'b0;
    end else begin
      d_q <= d_d;
      v_q <= v_d;
    end
  end
  assign d_out = d_q;
  assign v_out = v_q;
endmodule

// File: rtl/gated_shift_pipe.sv
// gated_shift_pipe: DEPTH-stage enable-gated delay line with valid tracking and occupancy
module gated_shift_pipe
  import gated_shift_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic                      flush,
  input  logic                      valid_in,
  input  logic [WIDTH-1:0]          data_in,
  output logic                      valid_out,
  output logic [WIDTH-1:0]          data_out,
  output logic [occ_w(DEPTH)-1:0]   occupancy
);
  localparam int OW = occ_w(DEPTH);
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [OW-1:0]    occ_q, occ_d;
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] d_src;
    logic             v_src;
    if (k == 0) begin : g_head
      assign d_src = data_in;
      assign v_src = valid_in;
    end else begin : g_body
      assign d_src = data_q[k-1];
      assign v_src = vld_q[k-1];
    end
    gated_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .clk(clk),
      .reset_n(reset_n),
      .en(en),
      .flush(flush),
      .v_in(v_src),
      .d_in(d_src),
      .v_out(vld_q[k]),
      .d_out(data_q[k])
    );
  end
  // occupancy is the popcount of the valid vector the stages are about to load
  always_comb begin
    vld_d = flush ? '0 : en ? (vld_q << 1) | DEPTH'(valid_in) : vld_q;
    occ_d = OW'(popcount(MAX_DEPTH'(vld_d)));
  end
  // occupancy register, updated on the same edge as the stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) occ_q <= '0;
    else occ_q <= occ_d;
  end
  assign data_out  = data_q[DEPTH-1];
  assign valid_out = vld_q[DEPTH-1];
  assign occupancy = occ_q;
endmodule

// File: tb/tb_gated_shift_pipe.sv
// tb_gated_shift_pipe: scoreboard bench for two pipes differing only in reset value
module tb_gated_shift_pipe;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0, flush = 1'b0, valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       vout0, vout1;
  logic [7:0] dout0, dout1;
  logic [2:0] occ0, occ1;
  int         n_vec = 0, n_err = 0;
  typedef struct packed {logic v; logic [7:0] d; logic f;} ent_t;
  ent_t       q[$];
  ent_t       dropped;

  gated_shift_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u0 (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .valid_in(valid_in),
    .data_in(data_in), .valid_out(vout0), .data_out(dout0), .occupancy(occ0)
  );
  gated_shift_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A)) u1 (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .valid_in(valid_in),
    .data_in(data_in), .valid_out(vout1), .data_out(dout1), .occupancy(occ1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    repeat (4) q.push_back('{1'b0, 8'h00, 1'b1});
  endtask

  task automatic compare();
    int cnt;
    cnt = 0;
    foreach (q[i]) cnt += int'(q[i].v);
    check("dout0", dout0, q[0].f ? 8'h00 : q[0].d);
    check("dout1", dout1, q[0].f ? 8'h5A : q[0].d);
    check("vout0", 8'(vout0), 8'(q[0].v));
    check("vout1", 8'(vout1), 8'(q[0].v));
    check("occ0", 8'(occ0), 8'(cnt));
    check("occ1", 8'(occ1), 8'(cnt));
  endtask

  task automatic step(input logic e, input logic f, input logic vi, input logic [7:0] di);
    en = e; flush = f; valid_in = vi; data_in = di;
    @(posedge clk);
    if (f) model_clear();
    else if (e) begin
      q.push_back('{vi, di, 1'b0});
      dropped = q.pop_front();
    end
    #1 compare();
  endtask

  initial begin
    model_clear();
    en = 1'b1; valid_in = 1'b1; data_in = 8'hAA;
    repeat (3) begin
      @(posedge clk);
      #1 compare();
    end
    reset_n = 1'b1;
    repeat (4) step(1'b1, 1'b0, 1'b1, 8'hAA);
    check("rst_aa", dout0, 8'hAA);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h55);
    step(1'b1, 1'b0, 1'b1, 8'h33);
    repeat (3) step(1'b0, 1'b0, 1'b1, 8'hEE);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("lat55", dout0, 8'h55);
    repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 1'b1, 8'(i));
    check("full_occ", 8'(occ0), 8'd4);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h99);
    step(1'b1, 1'b0, 1'b0, 8'hFF);
    step(1'b1, 1'b0, 1'b1, 8'hF0);
    step(1'b1, 1'b0, 1'b0, 8'hFF);
    repeat (4) step(1'b1, 1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'(8'hC0 + i));
    step(1'b1, 1'b1, 1'b1, 8'h77);
    check("flush_occ", 8'(occ0), 8'd0);
    repeat (5) step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h10 + i));
    check("pre_rst_occ", 8'(occ1), 8'd3);
    #2 reset_n = 1'b0;
    model_clear();
    #1 compare();
    check("arst_d1", dout1, 8'h5A);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, i[0], 8'(8'h20 + i));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
